// File: rtl/regfile_loader.sv
// regfile_loader: preloads a processor register file over a valid/ready beat stream,
// then releases the processor from reset for a bounded number of cycles.
module regfile_loader #(
   parameter int CYCLE_W        = 14,
   parameter int DEFAULT_CYCLES = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [CYCLE_W-1:0] run_cycles,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [4:0]         ld_reg,
   input  logic [31:0]        ld_data,
   input  logic               ld_last,
   input  logic               cpu_we,
   input  logic [4:0]         cpu_wreg,
   input  logic [31:0]        cpu_wdata,
   output logic               rf_we,
   output logic [4:0]         rf_wreg,
   output logic [31:0]        rf_wdata,
   output logic               cpu_reset,
   output logic               busy,
   output logic               done,
   output logic               err_r0,
   output logic [CYCLE_W-1:0] cycle_count
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state;
   logic [CYCLE_W-1:0] target;
   logic [CYCLE_W-1:0] count_next;
   logic accept;
   assign accept     = ld_valid & ld_ready;
   assign count_next = cycle_count + CYCLE_W'(1);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state       <= IDLE;
         ld_ready    <= 1'b0;
         cpu_reset   <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_r0      <= 1'b0;
         cycle_count <= '0;
         target      <= CYCLE_W'(DEFAULT_CYCLES);
      end else
         case (state)
            IDLE, DONE:
               if (start) begin
                  state       <= LOAD;
                  ld_ready    <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  err_r0      <= 1'b0;
                  cycle_count <= '0;
                  target      <= (run_cycles == '0) ? CYCLE_W'(DEFAULT_CYCLES) : run_cycles;
               end
            LOAD:
               if (accept) begin
                  if (ld_reg == 5'd0) err_r0 <= 1'b1;
                  if (ld_last) begin
                     state     <= RUN;
                     ld_ready  <= 1'b0;
                     cpu_reset <= 1'b0;
                  end
               end
            RUN: begin
               cycle_count <= count_next;
               // target is never 0, so the count stops before it could wrap
               if (count_next == target) begin
                  state     <= DONE;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end
            end
         endcase
   always_comb begin
      rf_we    = (state == LOAD) ? (accept && ld_reg != 5'd0) : (state == RUN) ? cpu_we : 1'b0;
      rf_wreg  = (state == RUN) ? cpu_wreg : ld_reg;
      rf_wdata = (state == RUN) ? cpu_wdata : ld_data;
   end
endmodule
